// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and a parity helper.
// Intended for reuse by the companion receiver.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 104;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses o_tick for one cycle
// on the last count of each bit. i_clear holds the counter at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  output logic o_tick
);

  localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = !i_clear && (r_cnt == LAST);

  // NOTE: state is written with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready input and a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [UART_DATA_BITS-1:0] TX_DATA,
  input  logic                      TX_VALID,
  output logic                      TX_READY,
  output logic                      TXD,
  output logic                      BUSY
);

  uart_state_e               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_hold;
  logic                      r_hold_full;
  logic [2:0]                r_bit_idx;
  logic                      r_txd;

  logic                      w_tick;
  logic                      w_accept;
  logic                      w_load;
  logic [UART_DATA_BITS-1:0] w_load_byte;

  assign TX_READY = !r_hold_full;
  assign TXD      = r_txd;
  assign BUSY     = (r_state != ST_IDLE) || r_hold_full;
  assign w_accept = TX_VALID && !r_hold_full;

  // The shifter is fed from the holding register when it is occupied, otherwise
  // straight from the input (accept while idle bypasses the hold).
  assign w_load_byte = r_hold_full ? r_hold : TX_DATA;
  assign w_load      = ((r_state == ST_IDLE) && (r_hold_full || w_accept)) ||
                       ((r_state == ST_STOP) && w_tick && r_hold_full);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_clear (r_state == ST_IDLE),
    .o_tick  (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= even_parity(w_load_byte);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_idx   <= '0;
      r_txd       <= 1'b1;
    end else begin
      if (w_accept && (r_state != ST_IDLE)) begin
        r_hold      <= TX_DATA;
        r_hold_full <= 1'b1;
      end

      if (w_load) begin
        r_shift     <= w_load_byte;
        r_hold_full <= 1'b0;
        r_state     <= ST_START;
        r_txd       <= 1'b0;
      end else begin
        case (r_state)
          ST_START: begin
            if (w_tick) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
              r_txd     <= r_shift[0];
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                r_state <= ST_PARITY;
                r_txd   <= r_parity;
`else
                r_state <= ST_STOP;
                r_txd   <= 1'b1;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= r_shift >> 1;
                r_txd     <= r_shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            if (w_tick) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (w_tick) begin
              r_state <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            r_txd <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
